// File: rtl/cordic_vectoring_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock on first-quadrant
// magnitudes, with the stripped input signs folded back into the final angle.
module cordic_vectoring_iter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int ITER        = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  x_in,
    input  logic [DATA_WIDTH-1:0]  y_in,
    input  logic                   x_neg,
    input  logic                   y_neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH:0]    mag_out,
    output logic [ANGLE_WIDTH-1:0] angle_out
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int CW = $clog2(ITER + 1);

    localparam logic [CW-1:0]          ITER_END = CW'(ITER);
    localparam logic [ANGLE_WIDTH-1:0] PI       = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef logic [ANGLE_WIDTH-1:0] atan_tab_t [ITER];

    // atan(2^-k) in angle units where +pi == 2^(ANGLE_WIDTH-1); the 16-bit table is
    // rescaled with rounding, and deep entries beyond it use atan(e) ~= e.
    function automatic atan_tab_t gen_atan();
        atan_tab_t t;
        longint    base;
        longint    v;
        for (int k = 0; k < ITER; k++) begin
            case (k)
                0:       base = 8192;
                1:       base = 4836;
                2:       base = 2555;
                3:       base = 1297;
                4:       base = 651;
                5:       base = 326;
                6:       base = 163;
                7:       base = 81;
                8:       base = 41;
                9:       base = 20;
                10:      base = 10;
                11:      base = 5;
                12:      base = 3;
                13:      base = 1;
                default: base = 0;
            endcase
            if (k >= 14)
                v = ((longint'(1) << (ANGLE_WIDTH - 1 - k)) * 2000000 + 3141593) / 6283186;
            else if (ANGLE_WIDTH >= 16)
                v = base << (ANGLE_WIDTH - 16);
            else
                v = (base + (longint'(1) << (15 - ANGLE_WIDTH))) >> (16 - ANGLE_WIDTH);
            t[k] = v[ANGLE_WIDTH-1:0];
        end
        return t;
    endfunction

    localparam atan_tab_t ATAN = gen_atan();

    state_t                  r_state;
    logic signed [XW-1:0]    r_x;
    logic signed [XW-1:0]    r_y;
    logic [ANGLE_WIDTH-1:0]  r_z;
    logic [CW-1:0]           r_iter;
    logic                    r_x_neg;
    logic                    r_y_neg;
    logic                    r_zero;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [DATA_WIDTH:0]     r_mag;
    logic [ANGLE_WIDTH-1:0]  r_angle;

    logic signed [XW-1:0]    w_x_sh;
    logic signed [XW-1:0]    w_y_sh;
    logic [ANGLE_WIDTH-1:0]  w_atan;
    logic                    w_y_pos;
    logic signed [XW-1:0]    w_x_next;
    logic signed [XW-1:0]    w_y_next;
    logic [ANGLE_WIDTH-1:0]  w_z_next;
    logic [ANGLE_WIDTH-1:0]  w_a;
    logic [ANGLE_WIDTH-1:0]  w_angle;

    // Both shifts see the pre-update x/y, so the micro-rotation is a true 2x2 step.
    assign w_x_sh  = r_x >>> r_iter;
    assign w_y_sh  = r_y >>> r_iter;
    assign w_atan  = (r_iter < ITER_END) ? ATAN[r_iter] : '0;
    assign w_y_pos = ~r_y[XW-1];

    assign w_x_next = w_y_pos ? (r_x + w_y_sh) : (r_x - w_y_sh);
    assign w_y_next = w_y_pos ? (r_y - w_x_sh) : (r_y + w_x_sh);
    assign w_z_next = w_y_pos ? (r_z + w_atan) : (r_z - w_atan);

    // Quadrant fold-back, all modulo 2^ANGLE_WIDTH so +pi lands on -pi.
    assign w_a     = r_x_neg ? (PI - r_z) : r_z;
    assign w_angle = r_y_neg ? ({ANGLE_WIDTH{1'b0}} - w_a) : w_a;

    // NOTE: the datapath is reset along with the FSM so an aborted sample leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_x_neg     <= 1'b0;
            r_y_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_angle     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= {2'b00, x_in};
                        r_y        <= {2'b00, y_in};
                        r_z        <= '0;
                        r_iter     <= '0;
                        r_x_neg    <= x_neg;
                        r_y_neg    <= y_neg;
                        r_zero     <= (x_in == '0) && (y_in == '0);
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_iter == ITER_END) begin
                        r_mag       <= r_zero ? '0 : r_x[DATA_WIDTH:0];
                        r_angle     <= r_zero ? '0 : w_angle;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_x    <= w_x_next;
                        r_y    <= w_y_next;
                        r_z    <= w_z_next;
                        r_iter <= r_iter + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign mag_out   = r_mag;
    assign angle_out = r_angle;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Scoreboard bench for cordic_vectoring_iter: expectations come from floating-point
// atan2/sqrt with the CORDIC gain, compared within fixed-point tolerances.
module tb_cordic_vectoring_iter;

    localparam int    DW        = 16;
    localparam int    AW        = 16;
    localparam int    ITER      = 14;
    localparam real   M_PI      = 3.14159265358979323846;
    localparam int    ANG_TOL   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_in = '0;
    logic [DW-1:0] y_in = '0;
    logic          x_neg = 1'b0;
    logic          y_neg = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW:0]   mag_out;
    logic [AW-1:0] angle_out;

    typedef struct {
        real mag;
        int  ang;
        bit  zero;
        int  acc_edge;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    real  k_gain;
    bit   rand_bp = 1'b0;

    cordic_vectoring_iter #(
        .DATA_WIDTH (DW),
        .ANGLE_WIDTH(AW),
        .ITER       (ITER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .x_neg    (x_neg),
        .y_neg    (y_neg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag_out  (mag_out),
        .angle_out(angle_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input bit xn, input bit yn, input int edge_no);
        exp_t e;
        real  xs;
        real  ys;
        int   a;
        e.acc_edge = edge_no;
        e.zero     = (x == 0) && (y == 0);
        if (e.zero) begin
            e.mag = 0.0;
            e.ang = 0;
        end else begin
            xs = xn ? -real'(x) : real'(x);
            ys = yn ? -real'(y) : real'(y);
            a  = int'($atan2(ys, xs) * 32768.0 / M_PI);
            if (a >= 32768) a -= 65536;
            e.ang = a;
            e.mag = k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        end
        return e;
    endfunction

    function automatic int ang_err(input logic [AW-1:0] act, input int req);
        logic [AW-1:0] d;
        int            sd;
        d  = act - AW'(req);
        sd = int'($signed(d));
        return (sd < 0) ? -sd : sd;
    endfunction

    task automatic send(input int x, input int y, input bit xn, input bit yn);
        int budget;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x_in     = DW'(x);
        y_in     = DW'(y);
        x_neg    = xn;
        y_neg    = yn;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 300) begin
                check("accept_timeout", 1'b0, 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        q.push_back(model(x, y, xn, yn, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = DW'($urandom);
        y_in     = DW'($urandom);
        x_neg    = 1'($urandom);
        y_neg    = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", n < 500, q.size(), 0);
    endtask

    // Monitor: latency on each rising out_valid, values on each handshake.
    initial begin : monitor
        bit   prev;
        exp_t e;
        real  diff;
        real  tol;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (q.size() == 0)
                        check("unexpected_out", 1'b0, 1, 0);
                    else
                        check("latency", (cyc - q[0].acc_edge) == ITER + 1,
                              cyc - q[0].acc_edge, ITER + 1);
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    if (e.zero) begin
                        check("zero_mag", mag_out == '0, mag_out, 0);
                        check("zero_angle", angle_out == '0, angle_out, 0);
                    end else begin
                        diff = real'(mag_out) - e.mag;
                        tol  = 8.0 + e.mag / 1024.0;
                        check("mag", (diff <= tol) && (diff >= -tol), mag_out, $rtoi(e.mag));
                        check("angle", ang_err(angle_out, e.ang) <= ANG_TOL,
                              $signed(angle_out), e.ang);
                    end
                end
                prev = out_valid;
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [DW:0]   m0;
        logic [AW-1:0] a0;
        int            n;
        int            rx;
        int            ry;

        k_gain = 1.0;
        for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready == 1'b1, in_ready, 1);
        check("idle_out_valid", out_valid == 1'b0, out_valid, 0);
        check("idle_mag", mag_out == '0, mag_out, 0);
        check("idle_angle", angle_out == '0, angle_out, 0);

        // Directed axis, diagonal, quadrant-fold and zero cases.
        send(1000, 0, 1'b0, 1'b0);
        drain();
        send(1000, 1000, 1'b0, 1'b0);
        send(1000, 1000, 1'b0, 1'b1);
        send(1000, 0, 1'b1, 1'b0);
        send(0, 1000, 1'b1, 1'b1);
        send(0, 0, 1'b0, 1'b0);
        send(0, 0, 1'b1, 1'b1);
        send(0, 0, 1'b1, 1'b0);
        send(32767, 32767, 1'b1, 1'b0);
        drain();

        // Output stall: result must hold and no new sample may enter.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(2000, 1500, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", out_valid == 1'b1, out_valid, 1);
        m0 = mag_out;
        a0 = angle_out;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x_in     = 16'd7;
        y_in     = 16'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid == 1'b1, out_valid, 1);
            check("hold_mag", mag_out == m0, mag_out, m0);
            check("hold_angle", angle_out == a0, angle_out, a0);
            check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", in_ready == 1'b1, in_ready, 1);
        check("release_out_valid", out_valid == 1'b0, out_valid, 0);
        send(3000, 4000, 1'b0, 1'b0);
        send(1200, 2500, 1'b1, 1'b0);
        drain();

        // Reset in the middle of the iterations discards the sample.
        send(5000, 5000, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("midrst_mag", mag_out == '0, mag_out, 0);
        check("midrst_angle", angle_out == '0, angle_out, 0);
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        send(3000, 4000, 1'b0, 1'b0);
        drain();

        // Random large-radius vectors, random signs, random consumer stalls.
        rand_bp = 1'b1;
        for (int s = 0; s < 40; s++) begin
            do begin
                rx = int'($urandom_range(0, 32767));
                ry = int'($urandom_range(0, 32767));
            end while ((longint'(rx) * rx + longint'(ry) * ry) < 64000000);
            send(rx, ry, 1'($urandom), 1'($urandom));
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
